filter_lookup_arb: RTL
======================

# filter_lookup_arb

Round-robin arbiter that shares one `filter` lookup engine among NUM_REQ header parsers, one parser per input port. It drives the engine's `hdr_rd`/`hdr_clear` handshake and holds the selected 5-tuple stable for the whole lookup. It captures the engine's `m_send` verdict into a per-requester result register and frees the engine right away. Statistics counters feed the register block.

## Interface
- NUM_REQ, 4: number of requesters (2..8).
- IP_ADDR_LEN, 32: IP field width.
- PORT_LEN, 16: L4 port field width.
- TIMEOUT_CYCLES, 16: watchdog limit in WAIT (only with FILTER_ARB_TIMEOUT_EN).

Ports:
- axi_aclk  in  1  sole clock.
- axi_reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  header from requester i is ready; level, held until verdict_valid[i].
- req_src_ip, req_dst_ip  in  NUM_REQ*IP_ADDR_LEN  packed headers; requester i at [i*W +: W].
- req_src_port, req_dst_port  in  NUM_REQ*PORT_LEN  packed ports.
- req_clear  in  NUM_REQ  one-cycle pulse; requester consumed its verdict.
- verdict_valid  out  NUM_REQ  verdict for requester i is held.
- verdict_send  out  NUM_REQ  1 = forward, 0 = drop; meaningful while verdict_valid[i].
- eng_hdr_rd, eng_hdr_clear  out  1  engine handshake pulses.
- eng_src_ip, eng_dst_ip  out  IP_ADDR_LEN  held header to engine.
- eng_src_port, eng_dst_port  out  PORT_LEN  held ports to engine.
- eng_send, eng_send_rd  in  1  engine verdict and verdict-ready.
- lookup_count, drop_count, timeout_count  out  32  statistics.

## Operation
- All outputs are registered. Reset values: every output 0, state IDLE, rr_ptr 0, all counters 0.
- A requester is eligible when req_valid[i]=1 and verdict_valid[i]=0.
- IDLE: if any requester is eligible, grant the first eligible index at or after rr_ptr, wrapping modulo NUM_REQ.
  - Latch that requester's 4 header fields into eng_* registers.
  - Set rr_ptr = grant+1 (mod NUM_REQ).
  - Go to ISSUE.
- ISSUE: eng_hdr_rd=1 for this single cycle. Go to WAIT.
- WAIT: eng_* fields stay constant.
  - eng_send_rd is sampled only from the 2nd WAIT cycle onward.
  - When it is 1: set verdict_send[g]=eng_send and verdict_valid[g]=1; increment lookup_count; increment drop_count if eng_send=0. Go to CLEAR.
- CLEAR: eng_hdr_clear=1 for one cycle. Go to IDLE.
- req_clear[i] with verdict_valid[i]=1: next cycle verdict_valid[i]=0 and verdict_send[i]=0.
- req_clear[i] with verdict_valid[i]=0: ignored.
- req_clear for one index and verdict capture for another in the same cycle: both take effect.
- req_valid dropped during a lookup: the lookup completes and the verdict is still posted.
- Header inputs are sampled only in IDLE; changes afterwards have no effect on the lookup in flight.
- Counters wrap modulo 2^32.
- Reset mid-lookup: returns to IDLE, clears all verdicts and counters. The engine shares the same reset, so no clear pulse is issued.

## Timing
- req_valid first seen in IDLE at cycle t:
  - eng_hdr_rd high at t+1.
  - eng_send_rd high at t+3.
  - verdict_valid high at t+4.
  - eng_hdr_clear high at t+4.
  - Back in IDLE at t+5.
- Back-to-back throughput: one lookup per 5 cycles.
- The engine's eng_send_rd stays high for one cycle after CLEAR. This overlaps IDLE only and is never sampled.
- No requester starves: worst-case wait is NUM_REQ-1 lookups.

## Configuration
- FILTER_ARB_TIMEOUT_EN defined:
  - A cycle counter runs in WAIT.
  - If eng_send_rd is not seen within TIMEOUT_CYCLES cycles of entering WAIT: post verdict_send[g]=0 and verdict_valid[g]=1; increment timeout_count and drop_count, not lookup_count; go to CLEAR.
- Not defined:
  - WAIT holds indefinitely.
  - timeout_count is tied to 0 and no watchdog logic is built.

## Test plan
- Single request, requester 0, src 0xAAFAAAAA, engine returns send=0 → verdict_valid[0] at t+4 with verdict_send[0]=0; lookup_count=1, drop_count=1.
- All 4 requesters asserted together from reset → grants in order 0,1,2,3, verdicts 5 cycles apart, eng_hdr_rd high exactly once per lookup.
- Requester 1 holds an unconsumed verdict while requesters 0 and 2 keep requesting → 1 is never regranted; 0 and 2 alternate; after req_clear[1], requester 1 is next served when rr_ptr reaches it.
- Header inputs change while in WAIT → eng_src_ip keeps its IDLE value; verdict matches the original header.
- Axi_reset asserted in WAIT → next cycle all outputs and counters are 0; a new request is then served at normal latency.
- With FILTER_ARB_TIMEOUT_EN, engine eng_send_rd held at 0 → after 16 WAIT cycles verdict_send=0 and timeout_count=1. Without the macro the arbiter stays in WAIT.

Source files
------------

// File: rtl/filter_lookup_arb.sv
// rtl/filter_lookup_arb.sv - round-robin arbiter sharing one filter lookup engine among NUM_REQ parsers
// Optional watchdog in WAIT is built only when FILTER_ARB_TIMEOUT_EN is defined.
module filter_lookup_arb #(
  parameter int NUM_REQ        = 4,
  parameter int IP_ADDR_LEN    = 32,
  parameter int PORT_LEN       = 16,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                          axi_aclk,
  input  logic                          axi_reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*IP_ADDR_LEN-1:0] req_src_ip,
  input  logic [NUM_REQ*IP_ADDR_LEN-1:0] req_dst_ip,
  input  logic [NUM_REQ*PORT_LEN-1:0]   req_src_port,
  input  logic [NUM_REQ*PORT_LEN-1:0]   req_dst_port,
  input  logic [NUM_REQ-1:0]            req_clear,
  output logic [NUM_REQ-1:0]            verdict_valid,
  output logic [NUM_REQ-1:0]            verdict_send,
  output logic                          eng_hdr_rd,
  output logic                          eng_hdr_clear,
  output logic [IP_ADDR_LEN-1:0]        eng_src_ip,
  output logic [IP_ADDR_LEN-1:0]        eng_dst_ip,
  output logic [PORT_LEN-1:0]           eng_src_port,
  output logic [PORT_LEN-1:0]           eng_dst_port,
  input  logic                          eng_send,
  input  logic                          eng_send_rd,
  output logic [31:0]                   lookup_count,
  output logic [31:0]                   drop_count,
  output logic [31:0]                   timeout_count
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CLEAR} state_t;

  state_t             state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   cur;
  logic               wait_first;
  logic [NUM_REQ-1:0] eligible;
  logic               grant_found;
  logic [PTR_W-1:0]   grant_idx;

`ifdef FILTER_ARB_TIMEOUT_EN
  localparam int WC_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WC_W-1:0] wait_cnt;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign timeout_count = '0;
`endif

  // A requester holding an unconsumed verdict is skipped so it cannot hog the engine.
  assign eligible = req_valid & ~verdict_valid;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_found && eligible[(int'(rr_ptr) + k) % NUM_REQ]) begin
        grant_found = 1'b1;
        grant_idx   = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
      end
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      cur           <= '0;
      wait_first    <= 1'b0;
      eng_hdr_rd    <= 1'b0;
      eng_hdr_clear <= 1'b0;
      eng_src_ip    <= '0;
      eng_dst_ip    <= '0;
      eng_src_port  <= '0;
      eng_dst_port  <= '0;
      verdict_valid <= '0;
      verdict_send  <= '0;
      lookup_count  <= '0;
      drop_count    <= '0;
`ifdef FILTER_ARB_TIMEOUT_EN
      wait_cnt      <= '0;
      timeout_count <= '0;
`endif
    end else begin
      eng_hdr_rd    <= 1'b0;
      eng_hdr_clear <= 1'b0;

      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_clear[i] && verdict_valid[i]) begin
          verdict_valid[i] <= 1'b0;
          verdict_send[i]  <= 1'b0;
        end
      end

      case (state)
        IDLE: begin
          if (grant_found) begin
            cur          <= grant_idx;
            eng_src_ip   <= req_src_ip[int'(grant_idx)*IP_ADDR_LEN +: IP_ADDR_LEN];
            eng_dst_ip   <= req_dst_ip[int'(grant_idx)*IP_ADDR_LEN +: IP_ADDR_LEN];
            eng_src_port <= req_src_port[int'(grant_idx)*PORT_LEN +: PORT_LEN];
            eng_dst_port <= req_dst_port[int'(grant_idx)*PORT_LEN +: PORT_LEN];
            rr_ptr       <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
            eng_hdr_rd   <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          wait_first <= 1'b1;
`ifdef FILTER_ARB_TIMEOUT_EN
          wait_cnt   <= '0;
`endif
          state      <= WAIT;
        end
        WAIT: begin
          wait_first <= 1'b0;
`ifdef FILTER_ARB_TIMEOUT_EN
          wait_cnt   <= wait_cnt + WC_W'(1);
`endif
          // The engine's verdict-ready from the previous lookup can linger; skip the first WAIT cycle.
          if (!wait_first && eng_send_rd) begin
            verdict_valid[cur] <= 1'b1;
            verdict_send[cur]  <= eng_send;
            lookup_count       <= lookup_count + 32'd1;
            if (!eng_send) drop_count <= drop_count + 32'd1;
            eng_hdr_clear      <= 1'b1;
            state              <= CLEAR;
          end
`ifdef FILTER_ARB_TIMEOUT_EN
          else if (wait_cnt == WC_W'(TIMEOUT_CYCLES - 1)) begin
            verdict_valid[cur] <= 1'b1;
            verdict_send[cur]  <= 1'b0;
            timeout_count      <= timeout_count + 32'd1;
            drop_count         <= drop_count + 32'd1;
            eng_hdr_clear      <= 1'b1;
            state              <= CLEAR;
          end
`endif
        end
        CLEAR: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
